// File: rtl/decode_ctrl_pkg.sv
// Shared types and widths for the decode issue controller.
//   INSTR_W / NPC_W : instruction word and next-PC widths
//   ENTRY_W         : width of one buffered {instr, npc} pair
//   dec_state_e     : issue-controller FSM state
package decode_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int NPC_W   = 16;
    localparam int ENTRY_W = INSTR_W + NPC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } dec_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: DEPTH entries of {instr, npc}, head read combinationally.
//   clk, rst   : clock, async active-low reset (pointers and count only)
//   clr        : synchronous clear of pointers and count
//   push/wdata : write wdata at the tail
//   pop        : advance the head
//   rdata      : current head entry
//   count      : occupancy, 0..DEPTH
module instr_fifo
    import decode_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ENTRY_W-1:0]      wdata,
    output logic [ENTRY_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: buffers fetched {instr, npc} pairs and issues them
// in order to decode, one per cycle, honouring stall and flush.
//   clk, rst                      : clock, async active-low reset
//   fetch_valid/instr/npc         : word offered by fetch
//   fetch_ready                   : buffer can accept a word this cycle
//   stall                         : decode cannot take a new instruction
//   flush                         : redirect; drop everything buffered
//   instr_dout, npc_in            : registered word presented to decode
//   enable_decode                 : one-cycle strobe marking a new word
//   count                         : buffer occupancy
//
// state | meaning
// IDLE  | buffer empty
// RUN   | words buffered, issuing when not stalled
// HOLD  | words buffered, decode stalled
// FLUSH | one cycle after a flush; fetch blocked
module decode_issue_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid,
    input  logic [INSTR_W-1:0]      fetch_instr,
    input  logic [NPC_W-1:0]        fetch_npc,
    output logic                    fetch_ready,
    input  logic                    stall,
    input  logic                    flush,
    output logic [INSTR_W-1:0]      instr_dout,
    output logic [NPC_W-1:0]        npc_in,
    output logic                    enable_decode,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    dec_state_e         state;
    dec_state_e         state_nxt;
    logic               push;
    logic               issue;
    logic [ENTRY_W-1:0] head;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (issue),
        .wdata ({fetch_instr, fetch_npc}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FLUSH;
        end else begin
            unique case (state)
                IDLE:  if (push) state_nxt = RUN;
                RUN: begin
                    if (stall)
                        state_nxt = HOLD;
                    else if (issue && count == ONE_CNT && !push)
                        state_nxt = IDLE;
                end
                HOLD:  if (!stall) state_nxt = RUN;
                FLUSH: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // fetch_ready ignores a same-cycle pop so a full buffer never chains
    // push readiness through the issue path.
    always_comb begin
        fetch_ready = (count < FULL_CNT) && (state != FLUSH);
        push        = fetch_valid && fetch_ready && !flush;
        issue       = (state == RUN) && (count != '0) && !stall && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_decode <= 1'b0;
            instr_dout    <= '0;
            npc_in        <= '0;
        end else begin
            enable_decode <= issue;
            if (issue) begin
                instr_dout <= head[ENTRY_W-1:NPC_W];
                npc_in     <= head[NPC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_instr = '0;
    logic [15:0] fetch_npc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_ready;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic        enable_decode;
    logic [2:0]  count;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_npc     (fetch_npc),
        .fetch_ready   (fetch_ready),
        .stall         (stall),
        .flush         (flush),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .enable_decode (enable_decode),
        .count         (count)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Model: a queue of buffered words plus two facts about the last edge.
    logic [31:0] mq[$];
    bit          m_flushing = 1'b0;  // last edge saw flush
    bit          m_held = 1'b0;      // last edge was stalled with words waiting
    bit          m_en = 1'b0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_npc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flushing = 1'b0;
        m_held = 1'b0;
        m_en = 1'b0;
        m_instr = '0;
        m_npc = '0;
    endtask

    // One clock edge: model decides from pre-edge inputs, then commits.
    task automatic cycle();
        bit do_push, do_issue, held_n;
        logic [31:0] hd;
        do_push  = fetch_valid && !m_flushing && (mq.size() < DEPTH) && !flush;
        do_issue = !flush && !m_flushing && !m_held && (mq.size() > 0) && !stall;
        held_n   = !flush && !m_flushing && stall && (mq.size() > 0);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_en = 1'b0;
            m_flushing = 1'b1;
            m_held = 1'b0;
        end else begin
            m_flushing = 1'b0;
            m_held = held_n;
            if (do_issue) begin
                hd = mq.pop_front();
                m_instr = hd[31:16];
                m_npc = hd[15:0];
                m_en = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            if (do_push) mq.push_back({fetch_instr, fetch_npc});
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_enable_decode", 32'(enable_decode), 32'(m_en));
            chk("m_instr_dout", 32'(instr_dout), 32'(m_instr));
            chk("m_npc_in", 32'(npc_in), 32'(m_npc));
            chk("m_fetch_ready", 32'(fetch_ready), 32'(!m_flushing && (mq.size() < DEPTH)));
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_en", 32'(enable_decode), 0);
        chk("rst_instr", 32'(instr_dout), 0);
        chk("rst_npc", 32'(npc_in), 0);
        chk("rst_ready", 32'(fetch_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        chk_on = 1'b1;

        // Single word latency
        fetch_valid = 1'b1; fetch_instr = 16'h1234; fetch_npc = 16'h3001;
        cycle();
        fetch_valid = 1'b0;
        chk("lat_en_k", 32'(enable_decode), 0);
        chk("lat_count_k", 32'(count), 1);
        cycle();
        chk("lat_en_k1", 32'(enable_decode), 1);
        chk("lat_instr", 32'(instr_dout), 32'h1234);
        chk("lat_npc", 32'(npc_in), 32'h3001);
        cycle();
        chk("lat_en_after", 32'(enable_decode), 0);
        chk("lat_instr_hold", 32'(instr_dout), 32'h1234);

        // Fill under stall, overflow attempt, then drain in order
        stall = 1'b1; fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_instr = 16'hA000 + 16'(i); fetch_npc = 16'hB000 + 16'(i);
            cycle();
            if (i == 3) begin
                chk("full_count", 32'(count), 4);
                chk("full_ready", 32'(fetch_ready), 0);
            end
        end
        chk("full_count_5th", 32'(count), 4);
        fetch_valid = 1'b0; stall = 1'b0;
        cycle();
        chk("unstall_gap_en", 32'(enable_decode), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("drain_en", 32'(enable_decode), 1);
            chk("drain_instr", 32'(instr_dout), 32'(16'hA000 + 16'(i)));
            chk("drain_npc", 32'(npc_in), 32'(16'hB000 + 16'(i)));
        end
        cycle();
        chk("drain_done_en", 32'(enable_decode), 0);
        chk("drain_done_count", 32'(count), 0);

        // Streaming through pointer wrap
        fetch_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fetch_instr = 16'h5000 + 16'(i); fetch_npc = 16'h6000 + 16'(i);
            cycle();
            chk("stream_count", 32'(count), 1);
            if (i > 0) begin
                chk("stream_en", 32'(enable_decode), 1);
                chk("stream_instr", 32'(instr_dout), 32'(16'h5000 + 16'(i - 1)));
            end
        end
        fetch_valid = 1'b0;
        cycle();
        chk("stream_last", 32'(instr_dout), 32'h5013);
        cycle();

        // Stall in the cycle a word is presented
        fetch_valid = 1'b1; fetch_instr = 16'h7001; fetch_npc = 16'h7101;
        cycle();
        fetch_instr = 16'h7002; fetch_npc = 16'h7102;
        cycle();
        chk("stl_en", 32'(enable_decode), 1);
        chk("stl_instr", 32'(instr_dout), 32'h7001);
        stall = 1'b1; fetch_valid = 1'b0;
        cycle();
        chk("stl_blocked_en", 32'(enable_decode), 0);
        chk("stl_blocked_count", 32'(count), 1);
        chk("stl_hold_instr", 32'(instr_dout), 32'h7001);
        cycle();
        stall = 1'b0;
        cycle();
        chk("stl_resume_gap", 32'(enable_decode), 0);
        cycle();
        chk("stl_resume_en", 32'(enable_decode), 1);
        chk("stl_resume_instr", 32'(instr_dout), 32'h7002);
        cycle();

        // Flush with count=3, fetch_valid and stall asserted; then a repeated flush
        stall = 1'b1; fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_instr = 16'h8000 + 16'(i); fetch_npc = 16'h8100 + 16'(i);
            cycle();
        end
        chk("pre_flush_count", 32'(count), 3);
        flush = 1'b1; fetch_instr = 16'h8003;
        cycle();
        chk("flush_count", 32'(count), 0);
        chk("flush_en", 32'(enable_decode), 0);
        chk("flush_ready", 32'(fetch_ready), 0);
        cycle();
        chk("reflush_ready", 32'(fetch_ready), 0);
        flush = 1'b0; fetch_instr = 16'h8004;
        cycle();
        chk("post_flush_ready", 32'(fetch_ready), 1);
        chk("post_flush_count", 32'(count), 0);
        fetch_valid = 1'b0; stall = 1'b0;
        cycle();

        // Async reset mid-stream with two words buffered
        stall = 1'b1; fetch_valid = 1'b1;
        fetch_instr = 16'h9000; fetch_npc = 16'h9100;
        cycle();
        fetch_instr = 16'h9001; fetch_npc = 16'h9101;
        cycle();
        fetch_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 2);
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_en", 32'(enable_decode), 0);
        chk("arst_instr", 32'(instr_dout), 0);
        chk("arst_npc", 32'(npc_in), 0);
        chk("arst_count", 32'(count), 0);
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0;
        fetch_valid = 1'b1; fetch_instr = 16'hAA01; fetch_npc = 16'hAB01;
        cycle();
        fetch_valid = 1'b0;
        chk("post_rst_en_k", 32'(enable_decode), 0);
        cycle();
        chk("post_rst_en", 32'(enable_decode), 1);
        chk("post_rst_instr", 32'(instr_dout), 32'hAA01);
        cycle();
        chk("post_rst_idle_en", 32'(enable_decode), 0);
        cycle();
        cycle();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: instruction buffer entries; power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 fetch_valid  in  1  fetch offers fetch_instr/fetch_npc this cycle.
REQ-005 fetch_instr  in  16  fetched LC3 instruction word.
REQ-006 fetch_npc  in  16  PC+1 of fetched instruction.
REQ-007 fetch_ready  out  1  buffer accepts a word this cycle.
REQ-008 stall  in  1  decode stage cannot take a new instruction this cycle.
REQ-009 flush  in  1  taken branch/redirect; discard all buffered and in-flight words.
REQ-010 instr_dout  out  16  instruction presented to decode.
REQ-011 npc_in  out  16  NPC presented to decode.
REQ-012 enable_decode  out  1  one-cycle qualifier: instr_dout/npc_in are new and valid.
REQ-013 count  out  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-014 Push occurs on a rising edge with fetch_valid && fetch_ready && !flush; the word pair is written at the tail.
REQ-015 fetch_ready is combinational: (count < DEPTH) && state != FLUSH; it does not depend on a same-cycle pop.
REQ-016 Issue occurs on a rising edge with state == RUN, count > 0, !stall, !flush: head pair registered into instr_dout/npc_in, enable_decode registered 1, head popped.
REQ-017 On any edge without an issue, enable_decode registers 0; instr_dout/npc_in hold their last values.
REQ-018 Latency: a word pushed at edge k into an empty buffer with no stall is presented with enable_decode=1 after edge k+1.
REQ-019 Issue order equals push order; no word is duplicated or skipped.
REQ-020 Simultaneous push and issue on one edge: count unchanged, both operations complete.
REQ-021 Pointers wrap modulo DEPTH; count saturates at neither end since push/issue are gated by full/empty.
REQ-022 States: IDLE (count==0), RUN (count>0, !stall), HOLD (count>0, stall), FLUSH.
REQ-023 Transitions: IDLE->RUN on push; RUN->HOLD on stall; HOLD->RUN on !stall; RUN->IDLE when last word issues with no push; any state->FLUSH on flush; FLUSH->IDLE unconditionally after one cycle.
REQ-024 flush has priority over stall, push and issue: at that edge count=0, pointers=0, enable_decode=0, same-cycle fetch word dropped.
REQ-025 In FLUSH, fetch_ready=0 and enable_decode=0; a flush asserted while in FLUSH restarts the one-cycle FLUSH.
REQ-026 stall asserted while enable_decode=1 does not retract that issued word; it only blocks the next issue.

Reset
REQ-027 rst low asynchronously sets state=IDLE, count=0, pointers=0, enable_decode=0, instr_dout=16'h0000, npc_in=16'h0000.
REQ-028 Reset asserted mid-operation discards all buffered words; first push after rst release behaves per REQ-018.
REQ-029 Buffer storage array is not reset.

Structure
REQ-030 Shared package decode_ctrl_pkg holds the state enum (IDLE, RUN, HOLD, FLUSH) and constants INSTR_W=16, NPC_W=16.
REQ-031 Storage and pointers live in one sub-module instr_fifo (DEPTH entries of 32 bits, push/pop/count); FSM and output registers live in decode_issue_ctrl.

Verification
REQ-032 Push 16'h1234/npc 16'h3001 into empty buffer, stall=0 -> enable_decode=1 with instr_dout=16'h1234, npc_in=16'h3001 exactly after second edge, then 0.
REQ-033 stall=1, push 5 words (DEPTH=4) -> fetch_ready=0 after 4th, count=4, 5th not accepted; release stall -> 4 words issue in order on 4 consecutive cycles.
REQ-034 Continuous fetch_valid with stall=0 for 20 cycles -> count stays 1, one enable_decode per cycle, order preserved through pointer wrap.
REQ-035 count=3, assert flush with fetch_valid=1 and stall=1 -> next cycle count=0, enable_decode=0, fetch_ready=0; following cycle fetch_ready=1, state IDLE.
REQ-036 rst low mid-stream with count=2 -> immediately enable_decode=0, outputs 16'h0000, count=0; after release, old words never issued.
REQ-037 stall asserted in the cycle enable_decode=1 -> that word counted issued once; next issue only after stall deasserts.
